// File: rtl/shift_deser_if.sv
// Serial-in / word-out handshake bundle for shift_deser.
// The master side drives the serial strobe and consumer ready; the slave side returns the word.
interface shift_deser_if #(
    parameter int unsigned WIDTH = 8
);
    logic             bit_in;
    logic             bit_vld;
    logic             msb_first;
    logic             clr;
    logic             dout_rdy;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             par_err;
    logic             ovf;

    modport master (
        output bit_in, bit_vld, msb_first, clr, dout_rdy,
        input  dout, dout_vld, par_err, ovf
    );

    modport slave (
        input  bit_in, bit_vld, msb_first, clr, dout_rdy,
        output dout, dout_vld, par_err, ovf
    );
endinterface

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: start bit, WIDTH data bits in either order,
// optional even-parity bit, single-entry output register with overflow flag.
module shift_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_deser_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sh_q;
    logic             msb_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;
    logic             perr_q;
    logic             ovf_q;

    logic [WIDTH-1:0] shift_d;
    logic             last_c;
    logic             done_c;
    logic [WIDTH-1:0] word_c;
    logic             perr_c;

    // Next shift value, frame-completion detect and the word/parity it would deliver
    always_comb begin
        shift_d = msb_q ? {sh_q[WIDTH-2:0], bus.bit_in} : {bus.bit_in, sh_q[WIDTH-1:1]};
        last_c  = (cnt_q == CNT_W'(WIDTH - 1));
        done_c  = 1'b0;
        word_c  = shift_d;
        perr_c  = 1'b0;
        if (bus.bit_vld && !bus.clr) begin
            if (state_q == DATA && last_c && !PARITY_EN) begin
                done_c = 1'b1;
            end
            if (state_q == PAR) begin
                done_c = 1'b1;
                word_c = sh_q;
                perr_c = ^{sh_q, bus.bit_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            msb_q      <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            perr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // Output register: a held, unaccepted word is never overwritten
            if (done_c) begin
                if (!dout_vld_q || bus.dout_rdy) begin
                    dout_q     <= word_c;
                    perr_q     <= perr_c;
                    dout_vld_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (dout_vld_q && bus.dout_rdy) begin
                dout_vld_q <= 1'b0;
            end

            if (bus.clr) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                sh_q    <= '0;
                ovf_q   <= 1'b0;
            end else if (bus.bit_vld) begin
                case (state_q)
                    IDLE: begin
                        if (!bus.bit_in) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            sh_q    <= '0;
                            msb_q   <= bus.msb_first;
                        end
                    end
                    DATA: begin
                        sh_q <= shift_d;
                        if (last_c) begin
                            cnt_q   <= '0;
                            state_q <= PARITY_EN ? PAR : IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PAR: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.par_err  = perr_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: a parity and a no-parity build share one serial stream and are
// tracked by a frame-level reference model, plus directed vectors and corner sequences.
module tb_shift_deser;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    bit   chk_en;

    shift_deser_if #(.WIDTH(8)) ifp ();
    shift_deser_if #(.WIDTH(8)) ifn ();

    shift_deser #(.WIDTH(8), .PARITY_EN(1'b1)) dut_p (.clk(clk), .rst_n(rst_n), .bus(ifp));
    shift_deser #(.WIDTH(8), .PARITY_EN(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(ifn));

    assign ifn.bit_in    = ifp.bit_in;
    assign ifn.bit_vld   = ifp.bit_vld;
    assign ifn.msb_first = ifp.msb_first;
    assign ifn.clr       = ifp.clr;
    assign ifn.dout_rdy  = ifp.dout_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: collects the bits of a frame, then builds the word arithmetically
    logic [32:0] m_buf  [2];
    int          m_cnt  [2];
    bit          m_in   [2];
    bit          m_msb  [2];
    bit          m_vld  [2];
    bit          m_perr [2];
    bit          m_ovf  [2];
    logic [7:0]  m_dout [2];

    task automatic model_step(input int k);
        int         need;
        bit         comp;
        logic [7:0] w;
        bit         pe;
        need = (k == 0) ? 9 : 8;
        comp = 1'b0;
        w    = '0;
        pe   = 1'b0;
        if (!rst_n) begin
            m_in[k] = 0; m_cnt[k] = 0; m_vld[k] = 0; m_perr[k] = 0; m_ovf[k] = 0; m_dout[k] = '0;
            return;
        end
        if (!ifp.clr && ifp.bit_vld) begin
            if (!m_in[k]) begin
                if (!ifp.bit_in) begin
                    m_in[k]  = 1;
                    m_cnt[k] = 0;
                    m_msb[k] = ifp.msb_first;
                end
            end else begin
                m_buf[k][m_cnt[k]] = ifp.bit_in;
                m_cnt[k]++;
                if (m_cnt[k] == need) begin
                    comp    = 1'b1;
                    m_in[k] = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (m_msb[k]) w[7-i] = m_buf[k][i];
                        else          w[i]   = m_buf[k][i];
                    end
                    pe = (k == 0) ? ((^w) ^ m_buf[k][8]) : 1'b0;
                end
            end
        end
        if (ifp.clr) begin
            m_in[k]  = 0;
            m_ovf[k] = 0;
        end
        if (comp) begin
            if (!m_vld[k] || ifp.dout_rdy) begin
                m_dout[k] = w;
                m_perr[k] = pe;
                m_vld[k]  = 1;
            end else begin
                m_ovf[k] = 1;
            end
        end else if (m_vld[k] && ifp.dout_rdy) begin
            m_vld[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_p", {21'd0, ifp.dout_vld, ifp.ovf, ifp.dout_vld ? {ifp.dout, ifp.par_err} : 9'd0},
                             {21'd0, m_vld[0], m_ovf[0], m_vld[0] ? {m_dout[0], m_perr[0]} : 9'd0});
            check("model_n", {21'd0, ifn.dout_vld, ifn.ovf, ifn.dout_vld ? {ifn.dout, ifn.par_err} : 9'd0},
                             {21'd0, m_vld[1], m_ovf[1], m_vld[1] ? {m_dout[1], m_perr[1]} : 9'd0});
        end
    end

    // All driving tasks start and end on a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input bit b);
        ifp.bit_vld = 1'b1;
        ifp.bit_in  = b;
        @(negedge clk);
        ifp.bit_vld = 1'b0;
        ifp.bit_in  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit msb, input bit with_par, input bit pbit,
                              input int gap, input bit rdy_last, input bit quiet);
        bit b;
        bit last;
        ifp.msb_first = msb;
        strobe(1'b0);
        idle(gap);
        for (int i = 0; i < 8; i++) begin
            b    = msb ? d[7-i] : d[i];
            last = (i == 7) && !with_par;
            if (last && rdy_last) ifp.dout_rdy = 1'b1;
            strobe(b);
            if (!last) begin
                if (quiet) check("early_vld", 32'(ifp.dout_vld), 32'd0);
                idle(gap);
            end
        end
        if (with_par) begin
            if (rdy_last) ifp.dout_rdy = 1'b1;
            strobe(pbit);
        end
        if (rdy_last) ifp.dout_rdy = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         msb;
        bit         pbit;
        int         gap;
        logic [7:0] exp_dout;
        bit         exp_perr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_in[k] = 0; m_cnt[k] = 0; m_msb[k] = 0; m_vld[k] = 0;
            m_perr[k] = 0; m_ovf[k] = 0; m_dout[k] = '0; m_buf[k] = '0;
        end
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 0, 8'hA5, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 2, 8'h3C, 1'b0};
        tbl[2] = '{8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b1};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b0};
        tbl[5] = '{8'h81, 1'b1, 1'b0, 3, 8'h81, 1'b0};

        rst_n         = 1'b0;
        ifp.bit_in    = 1'b0;
        ifp.bit_vld   = 1'b0;
        ifp.msb_first = 1'b0;
        ifp.clr       = 1'b0;
        ifp.dout_rdy  = 1'b0;
        idle(2);
        chk_en = 1'b1;
        check("rst_state_p", {22'd0, ifp.dout, ifp.dout_vld, ifp.par_err}, 32'd0);
        check("rst_ovf_p", 32'(ifp.ovf), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Directed frames with the consumer always ready
        ifp.dout_rdy = 1'b1;
        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].msb, 1'b1, tbl[i].pbit, tbl[i].gap, 1'b0, 1'b1);
            check($sformatf("tbl%0d_vld", i), 32'(ifp.dout_vld), 32'd1);
            check($sformatf("tbl%0d_dout", i), 32'(ifp.dout), 32'(tbl[i].exp_dout));
            check($sformatf("tbl%0d_perr", i), 32'(ifp.par_err), 32'(tbl[i].exp_perr));
            idle(1);
            check($sformatf("tbl%0d_vld_drop", i), 32'(ifp.dout_vld), 32'd0);
        end

        // clr beats a simultaneous start bit
        ifp.clr = 1'b1;
        strobe(1'b0);
        ifp.clr = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        check("clr_prio_dout", 32'(ifp.dout), 32'h000000A5);
        idle(1);

        // Backpressure then overflow, drain, clear
        ifp.dout_rdy = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("bp_first", {23'd0, ifp.dout_vld, ifp.dout}, {23'd0, 1'b1, 8'hA5});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        check("bp_hold", {22'd0, ifp.ovf, ifp.dout_vld, ifp.dout}, {22'd0, 1'b1, 1'b1, 8'hA5});
        ifp.dout_rdy = 1'b1;
        idle(1);
        check("bp_drain", {30'd0, ifp.dout_vld, ifp.ovf}, {30'd0, 1'b0, 1'b1});
        ifp.dout_rdy = 1'b0;
        ifp.clr      = 1'b1;
        idle(1);
        ifp.clr = 1'b0;
        check("bp_clr", 32'(ifp.ovf), 32'd0);

        // Same-cycle handoff while a word is held
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        check("handoff", {22'd0, ifp.ovf, ifp.dout_vld, ifp.dout}, {22'd0, 1'b0, 1'b1, 8'h3C});
        ifp.dout_rdy = 1'b1;
        idle(2);

        // Reset mid-frame, then a clean frame on the no-parity build
        ifp.msb_first = 1'b0;
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("rst_mid_n", {21'd0, ifn.dout, ifn.dout_vld, ifn.par_err, ifn.ovf}, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("rst_frame_n", {22'd0, ifn.dout_vld, ifn.par_err, ifn.dout}, {22'd0, 1'b1, 1'b0, 8'h5A});
        idle(1);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst_n         = ($urandom_range(0, 599) != 0);
            ifp.bit_vld   = $urandom_range(0, 1) == 1;
            ifp.bit_in    = ($urandom_range(0, 3) != 0);
            ifp.msb_first = $urandom_range(0, 1) == 1;
            ifp.clr       = ($urandom_range(0, 79) == 0);
            ifp.dout_rdy  = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        rst_n       = 1'b1;
        ifp.bit_vld = 1'b0;
        ifp.clr     = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame (range 2..32).
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning an even-parity bit follows the data bits (1) or is absent (0).
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port bit_in  input  1  serial data bit, sampled only when bit_vld=1.
REQ-006 SHALL have port bit_vld  input  1  bit strobe; one serial bit per cycle with bit_vld=1.
REQ-007 SHALL have port msb_first  input  1  frame bit order (1=MSB first, 0=LSB first), sampled with the start bit.
REQ-008 SHALL have port clr  input  1  synchronous frame abort and overflow-flag clear.
REQ-009 SHALL have port dout_rdy  input  1  consumer ready.
REQ-010 SHALL have port dout  output  WIDTH  assembled data word.
REQ-011 SHALL have port dout_vld  output  1  dout/par_err valid.
REQ-012 SHALL have port par_err  output  1  parity mismatch for the word on dout; 0 when PARITY_EN=0.
REQ-013 SHALL have port ovf  output  1  sticky flag: a completed frame was dropped.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, PAR; all state changes happen only on cycles with bit_vld=1, except clr and reset.
REQ-015 IDLE: bit_vld=1 with bit_in=0 (start bit) SHALL go to DATA, clear the bit counter, clear the shift register and latch msb_first; bit_in=1 SHALL stay in IDLE.
REQ-016 DATA, LSB-first: each strobe SHALL shift right, inserting bit_in at bit WIDTH-1.
REQ-017 DATA, MSB-first: each strobe SHALL shift left, inserting bit_in at bit 0.
REQ-018 DATA: after the WIDTH-th data strobe SHALL go to PAR if PARITY_EN=1, else complete the frame and go to IDLE.
REQ-019 PAR: the strobe SHALL compute par_err = XOR(data bits, parity bit), complete the frame and go to IDLE.
REQ-020 Cycles with bit_vld=0 SHALL hold state, counter and shift register; there is no timeout.
REQ-021 Frame completion SHALL load dout/par_err and set dout_vld on the same edge that samples the final strobe; the word is visible the next cycle.
REQ-022 dout, par_err and dout_vld SHALL stay stable while dout_vld=1 and dout_rdy=0.
REQ-023 dout_vld=1 with dout_rdy=1 and no completion SHALL clear dout_vld on that edge.
REQ-024 Completion while dout_vld=0, or in the same cycle as dout_vld=1 with dout_rdy=1, SHALL load the new word and keep dout_vld=1.
REQ-025 Completion while dout_vld=1 and dout_rdy=0 SHALL drop the new word, keep the held word and set ovf.
REQ-026 ovf SHALL remain 1 until clr or reset.
REQ-027 Reception SHALL continue while dout_vld=1; overflow is judged only at completion.
REQ-028 clr=1 SHALL force IDLE, clear the counter, shift register and ovf, and leave dout/dout_vld/par_err and the output handshake unaffected.
REQ-029 clr SHALL have priority over a simultaneous bit_vld; that bit is discarded.

Reset
REQ-030 rst_n=0 SHALL, on the clock edge, set state IDLE, counter 0, shift register 0, dout=0, dout_vld=0, par_err=0 and ovf=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first bit_vld after release is treated as a potential start bit.
REQ-032 Reset SHALL have priority over clr, bit_vld and dout_rdy.

Verification (WIDTH=8, PARITY_EN=1 unless noted)
REQ-033 LSB-first: start 0, bits 1,0,1,0,0,1,0,1, parity 0, dout_rdy=1 -> dout=0xA5, par_err=0, dout_vld high one cycle.
REQ-034 MSB-first with idle gaps between strobes: start 0, bits 0,0,1,1,1,1,0,0, parity 0 -> dout=0x3C, par_err=0, no early dout_vld.
REQ-035 Same bits as REQ-033 with parity 1 -> dout=0xA5, par_err=1.
REQ-036 Backpressure: dout_rdy=0; frames 0xA5 then 0x3C -> dout holds 0xA5, ovf=1 after the second frame; then dout_rdy=1 -> dout_vld drops, ovf stays 1; then clr -> ovf=0.
REQ-037 Same-cycle handoff: dout_rdy pulses on the cycle the 0x3C frame's parity strobe arrives while 0xA5 is held -> dout=0x3C, dout_vld stays 1, ovf=0.
REQ-038 rst_n=0 after 4 data bits, then a full 0x5A frame (PARITY_EN=0 build) -> dout=0x5A, par_err=0, no stale bits.
